// File: rtl/cond_pkg.sv
// Shared types and bit positions for the conditional-execution stage.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a condition code against an NZCV flag set.
module cond_check
  import cond_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Decode condition code; the reserved encoding never executes.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z_s;
      COND_NE: cond_ex = ~z_s;
      COND_CS: cond_ex = c_s;
      COND_CC: cond_ex = ~c_s;
      COND_MI: cond_ex = n_s;
      COND_PL: cond_ex = ~n_s;
      COND_VS: cond_ex = v_s;
      COND_VC: cond_ex = ~v_s;
      COND_HI: cond_ex = c_s & ~z_s;
      COND_LS: cond_ex = ~c_s | z_s;
      COND_GE: cond_ex = (n_s == v_s);
      COND_LT: cond_ex = (n_s != v_s);
      COND_GT: cond_ex = ~z_s & (n_s == v_s);
      COND_LE: cond_ex = z_s | (n_s != v_s);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// NZCV status register, condition gating of write enables and optional
// executed/squashed counters (enabled by defining COND_PERF_EN).
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  cond_e      cond_s;
  logic       cond_ex_s;
  logic       exec_s;
  logic [3:0] flags_r;

  assign cond_s = cond_e'(Cond);
  assign exec_s = InstrValid & cond_ex_s;
  assign Flags  = flags_r;

  // Evaluated against the registered flags only, so same-cycle ALU flags never feed back.
  cond_check u_cond_check (
    .cond    (cond_s),
    .flags   (flags_r),
    .cond_ex (cond_ex_s)
  );

  // Status register: the NZ and CV halves update independently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r <= RESET_FLAGS;
    end else begin
      if (exec_s & FlagW[FLAGW_NZ]) begin
        flags_r[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end else begin
        flags_r[FLAG_N:FLAG_Z] <= flags_r[FLAG_N:FLAG_Z];
      end
      if (exec_s & FlagW[FLAGW_CV]) begin
        flags_r[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end else begin
        flags_r[FLAG_C:FLAG_V] <= flags_r[FLAG_C:FLAG_V];
      end
    end
  end

  // Side-effect gating; everything is held off while reset is asserted.
  always_comb begin
    CondEx   = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    if (!rst_n) begin
      CondEx   = 1'b0;
      PCSrc    = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end else begin
      CondEx   = cond_ex_s;
      PCSrc    = PCS & exec_s;
      RegWrite = RegW & ~NoWrite & exec_s;
      MemWrite = MemW & exec_s;
    end
  end

`ifdef COND_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] exec_cnt_r;
  logic [CNT_W-1:0] squash_cnt_r;

  // Saturating counts of executed and squashed valid instructions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exec_cnt_r   <= {CNT_W{1'b0}};
      squash_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (InstrValid & cond_ex_s & (exec_cnt_r != CNT_MAX)) begin
        exec_cnt_r <= exec_cnt_r + CNT_ONE;
      end else begin
        exec_cnt_r <= exec_cnt_r;
      end
      if (InstrValid & ~cond_ex_s & (squash_cnt_r != CNT_MAX)) begin
        squash_cnt_r <= squash_cnt_r + CNT_ONE;
      end else begin
        squash_cnt_r <= squash_cnt_r;
      end
    end
  end

  assign ExecCnt   = exec_cnt_r;
  assign SquashCnt = squash_cnt_r;
`else
  assign ExecCnt   = {CNT_W{1'b0}};
  assign SquashCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Randomized and directed bench for cond_unit against a behavioural model.
module tb_cond_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          InstrValid;
  logic [3:0]    Cond;
  logic [3:0]    ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS, RegW, MemW, NoWrite;
  logic          CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]    Flags;
  logic [CW-1:0] ExecCnt, SquashCnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] m_flags;
  int         m_exec, m_squash;

  cond_unit #(.RESET_FLAGS(4'b0000), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .InstrValid(InstrValid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Conditions come in true/inverted pairs selected by the low bit of the code.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic rw,
                       input logic mw, input logic nw);
    InstrValid = v; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
  endtask

  // Check combinational outputs mid-cycle, clock once, then advance the model.
  task automatic step();
    logic pass, go;
    #3;
    pass = cond_ref(Cond, m_flags);
    go   = rst_n && pass;
    check_eq("CondEx",   CondEx,   go);
    check_eq("PCSrc",    PCSrc,    go && InstrValid && PCS);
    check_eq("RegWrite", RegWrite, go && InstrValid && RegW && !NoWrite);
    check_eq("MemWrite", MemWrite, go && InstrValid && MemW);
    check_eq("Flags",    Flags,    m_flags);
`ifdef COND_PERF_EN
    check_eq("ExecCnt",   ExecCnt,   m_exec);
    check_eq("SquashCnt", SquashCnt, m_squash);
`else
    check_eq("ExecCnt0",   ExecCnt,   0);
    check_eq("SquashCnt0", SquashCnt, 0);
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_flags = 4'b0000; m_exec = 0; m_squash = 0;
    end else if (InstrValid) begin
      if (pass) begin
        if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
        if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
        if (m_exec < 15) m_exec++;
      end else if (m_squash < 15) begin
        m_squash++;
      end
    end
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1'b1, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    m_flags = 4'b0000; m_exec = 0; m_squash = 0;

    // Reset with all write requests high.
    #1;
    check_eq("rst_regwrite", RegWrite, 0);
    check_eq("rst_pcsrc",    PCSrc,    0);
    check_eq("rst_memwrite", MemWrite, 0);
    step();
    check_eq("rst_flags", Flags, 4'b0000);
    rst_n = 1'b1;

    // Flag latch, then EQ/NE against new flags.
    drive(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("latch_0100", Flags, 4'b0100);
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; check_eq("eq_regwrite", RegWrite, 1);
    step();
    drive(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; check_eq("ne_regwrite", RegWrite, 0);
    step();

    // Split half updates.
    set_flags(4'b0000);
    drive(1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("split_nz", Flags, 4'b1100);
    drive(1'b1, 4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("split_cv", Flags, 4'b1111);

    // Failed condition has no side effects.
    set_flags(4'b0000);
    drive(1'b1, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("fail_condex", CondEx,   0);
    check_eq("fail_memw",   MemWrite, 0);
    step();
    check_eq("fail_flags", Flags, 4'b0000);

    // Signed compares with N=1, V=0.
    set_flags(4'b1000);
    drive(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check_eq("ge", CondEx, 0);
    Cond = 4'b1011; #1; check_eq("lt", CondEx, 1);
    Cond = 4'b1100; #1; check_eq("gt", CondEx, 0);
    Cond = 4'b1101; #1; check_eq("le", CondEx, 1);
    Cond = 4'b1111; #1; check_eq("nv", CondEx, 0);
    step();

    // Reset in the middle of a flag-writing instruction.
    set_flags(4'b1010);
    rst_n = 1'b0;
    drive(1'b1, 4'b1110, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_eq("midrst_flags", Flags, 4'b0000);
    rst_n = 1'b1;

    // Bubbles hold the flags.
    drive(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_eq("bubble_flags", Flags, 4'b0000);

    // Full sweep: every flag value against every condition code.
    for (int f = 0; f < 16; f++) begin
      set_flags(f[3:0]);
      for (int c = 0; c < 16; c++) begin
        drive(1'b0, c[3:0], 4'(f + 1), 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
      end
    end

`ifdef COND_PERF_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    end
    check_eq("perf_exec5",   ExecCnt,   5);
    check_eq("perf_squash3", SquashCnt, 3);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    end
    check_eq("perf_sat", ExecCnt, 15);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(31) != 0);
      drive(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
